// File: rtl/reg_file_sb_if.sv
// Register-file bus: writeback port, two read ports and the issue/scoreboard handshake.
interface reg_file_sb_if #(
    parameter int DATA_W = 32
);
    logic              WE;
    logic [4:0]        WP;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        RP1;
    logic [4:0]        RP2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              isIssue;
    logic [4:0]        IssueRd;
    logic              Busy1;
    logic              Busy2;
    logic              Stall;

    modport master (
        output WE, WP, WriteData, RP1, RP2, isIssue, IssueRd,
        input  ReadData1, ReadData2, Busy1, Busy2, Stall
    );

    modport slave (
        input  WE, WP, WriteData, RP1, RP2, isIssue, IssueRd,
        output ReadData1, ReadData2, Busy1, Busy2, Stall
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a per-register pending-write scoreboard for issue stalls.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data and pend clears to the read ports.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    logic [DATA_W-1:0] regMem [NREGS];
    logic [NREGS-1:0]  pend;

    logic wpValid;
    logic issueValid;
    logic rp1Valid;
    logic rp2Valid;

    assign wpValid    = (32'(bus.WP) < NREGS);
    assign issueValid = (32'(bus.IssueRd) < NREGS);
    assign rp1Valid   = (32'(bus.RP1) < NREGS);
    assign rp2Valid   = (32'(bus.RP2) < NREGS);

    // Clear is applied before set so a same-edge reissue of the written register stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regMem[i] <= '0;
            end
            pend <= '0;
        end else begin
            if (bus.WE && wpValid) begin
                regMem[bus.WP] <= bus.WriteData;
                pend[bus.WP]   <= 1'b0;
            end
            if (bus.isIssue && issueValid) begin
                pend[bus.IssueRd] <= 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] storedData1;
    logic [DATA_W-1:0] storedData2;
    logic              storedPend1;
    logic              storedPend2;

    always_comb begin
        storedData1 = '0;
        storedData2 = '0;
        storedPend1 = 1'b0;
        storedPend2 = 1'b0;
        if (rp1Valid) begin
            storedData1 = regMem[bus.RP1];
            storedPend1 = pend[bus.RP1];
        end
        if (rp2Valid) begin
            storedData2 = regMem[bus.RP2];
            storedPend2 = pend[bus.RP2];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;
    logic reissue;

    // Forwarding is masked during reset so the ports show the cleared state.
    assign fwd1    = rst_n && bus.WE && wpValid && (bus.WP == bus.RP1);
    assign fwd2    = rst_n && bus.WE && wpValid && (bus.WP == bus.RP2);
    assign reissue = bus.isIssue && (bus.IssueRd == bus.WP);

    always_comb begin
        bus.ReadData1 = storedData1;
        bus.ReadData2 = storedData2;
        bus.Busy1     = storedPend1;
        bus.Busy2     = storedPend2;
        if (fwd1) begin
            bus.ReadData1 = bus.WriteData;
            bus.Busy1     = reissue;
        end
        if (fwd2) begin
            bus.ReadData2 = bus.WriteData;
            bus.Busy2     = reissue;
        end
    end
`else
    always_comb begin
        bus.ReadData1 = storedData1;
        bus.ReadData2 = storedData2;
        bus.Busy1     = storedPend1;
        bus.Busy2     = storedPend2;
    end
`endif

    assign bus.Stall = bus.Busy1 | bus.Busy2;

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data-port width.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers, addressed by 5-bit indices.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port `clk`: input, 1 bit, rising-edge clock.
REQ-005 Port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-006 Port `WE`: input, 1 bit, writeback-stage write enable.
REQ-007 Port `WP`: input, 5 bits, writeback destination index (31 for call return address).
REQ-008 Port `WriteData`: input, DATA_W bits, writeback value.
REQ-009 Port `RP1`: input, 5 bits, read-port-1 index.
REQ-010 Port `RP2`: input, 5 bits, read-port-2 index.
REQ-011 Port `ReadData1`: output, DATA_W bits, read-port-1 data.
REQ-012 Port `ReadData2`: output, DATA_W bits, read-port-2 data.
REQ-013 Port `isIssue`: input, 1 bit, decode issues an instruction that writes a register.
REQ-014 Port `IssueRd`: input, 5 bits, destination of the issued instruction.
REQ-015 Port `Busy1`: output, 1 bit, RP1 has a pending write.
REQ-016 Port `Busy2`: output, 1 bit, RP2 has a pending write.
REQ-017 Port `Stall`: output, 1 bit, equals Busy1 OR Busy2.

Function
REQ-018 The block SHALL contain NREGS x DATA_W storage plus NREGS pending bits.
REQ-019 Writes SHALL happen on the rising edge of `clk`: when WE=1, reg[WP] <= WriteData.
REQ-020 When WE=0, storage SHALL be unchanged.
REQ-021 Reads SHALL be combinational: ReadDataN = reg[RPN], with zero-cycle latency.
REQ-022 Both read ports SHALL be independent and MAY address the same register.
REQ-023 On a rising edge, pend[IssueRd] SHALL be set to 1 when isIssue=1.
REQ-024 On a rising edge, pend[WP] SHALL be cleared to 0 when WE=1.
REQ-025 When isIssue=1 and WE=1 with IssueRd==WP in the same edge, the set SHALL win and pend stays 1 (the new producer is outstanding).
REQ-026 When isIssue=1 and WE=1 with IssueRd!=WP, both updates SHALL apply.
REQ-027 BusyN SHALL equal pend[RPN], subject to REQ-033.
REQ-028 Stall SHALL be purely combinational from BusyN.
REQ-029 A WE to a register whose pend bit is 0 SHALL be legal and SHALL only update storage.

Reset
REQ-030 While rst_n=0, all registers SHALL be 0 and all pend bits 0, immediately and without waiting for a clock edge.
REQ-031 Reset asserted mid-operation SHALL discard all pending writes, and outputs SHALL follow cleared state: ReadData=0 and Busy=0.
REQ-032 After deassertion, the first write SHALL take effect at the next rising edge.

Configuration
REQ-033 With macro REGFILE_BYPASS_EN defined, when WE=1 and WP==RPN in the same cycle:
- ReadDataN SHALL equal WriteData combinationally.
- BusyN SHALL read 0, unless isIssue=1 with IssueRd==WP.
REQ-034 Without REGFILE_BYPASS_EN:
- ReadDataN SHALL return the stored (old) value.
- BusyN SHALL reflect the stored pend bit until the edge after the write.

Verification
REQ-035 Reset then read: rst_n=0 -> ReadData1=ReadData2=0, Busy1=Busy2=Stall=0; release reset, RP1=31 -> ReadData1=0.
REQ-036 Write then read: WE=1, WP=5, WriteData=0xDEADBEEF, one edge, WE=0; RP1=RP2=5 -> ReadData1=ReadData2=0xDEADBEEF.
REQ-037 Scoreboard: isIssue=1, IssueRd=7, edge -> with RP2=7, Busy2=1 and Stall=1; then WE=1, WP=7, WriteData=0x12, edge -> Busy2=0 and ReadData2=0x12.
REQ-038 Same-cycle write/read with reg 3 holding 0x1 and WE=1, WP=3, WriteData=0x55, RP1=3, checked before the edge:
- With bypass: ReadData1=0x55.
- Without bypass: ReadData1=0x1.
REQ-039 Simultaneous set/clear: pend[31]=1, then isIssue=1, IssueRd=31 and WE=1, WP=31, WriteData=0x40 on one edge -> reg31=0x40 and Busy1 (RP1=31)=1 afterwards.
REQ-040 Async reset mid-stream: pend[4]=1 and reg4=0x9; drop rst_n between edges -> Busy and ReadData for RP1=4 become 0 with no clock edge.
